adam_dmi_arb: RTL and testbench

Arbitrates the RISC-V Debug Module Interface (DMI) between several debug masters and one debug module. Masters include the JTAG DTM and a memory-mapped debug bridge.
- Round-robin grant; exactly one transaction outstanding at a time.
- Grant is held from request acceptance until the response is consumed.
- Sits in the debug subsystem, between the DTM/bridges and the DM, in the same clock domain.

---
 rtl/adam_dmi_arb.sv | 276 +++++++++++++++++++++++++++
 tb/tb_adam_dmi_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adam_dmi_arb.sv
// adam_dmi_arb: round-robin arbiter sharing one RISC-V Debug Module Interface
// (DMI) between several debug masters (JTAG DTM, memory-mapped bridge, ...).
// Only one transaction is in flight at a time. The granted master keeps the
// grant from request acceptance until it consumes the response.
//
// Optional build macro: ADAM_DMI_ARB_TIMEOUT_EN
//   Defined   - a cycle counter aborts a transaction the DM does not answer
//               within TIMEOUT cycles. The master then receives status 2
//               (failed), and one late DM response is drained and discarded.
//   Undefined - FWD/WAIT wait indefinitely and TIMEOUT has no effect.
module adam_dmi_arb #(
    parameter int NO_MSTS = 2,
    parameter int ABITS   = 7,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NO_MSTS-1:0]       mst_req_valid,
    output logic [NO_MSTS-1:0]       mst_req_ready,
    input  logic [NO_MSTS*ABITS-1:0] mst_req_addr,
    input  logic [NO_MSTS*32-1:0]    mst_req_data,
    input  logic [NO_MSTS*2-1:0]     mst_req_op,
    output logic [NO_MSTS-1:0]       mst_resp_valid,
    input  logic [NO_MSTS-1:0]       mst_resp_ready,
    output logic [31:0]              mst_resp_data,
    output logic [1:0]               mst_resp_op,
    output logic                     dm_req_valid,
    input  logic                     dm_req_ready,
    output logic [ABITS-1:0]         dm_req_addr,
    output logic [31:0]              dm_req_data,
    output logic [1:0]               dm_req_op,
    input  logic                     dm_resp_valid,
    output logic                     dm_resp_ready,
    input  logic [31:0]              dm_resp_data,
    input  logic [1:0]               dm_resp_op
);

    localparam int PW = (NO_MSTS > 1) ? $clog2(NO_MSTS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_WR   = 2'd2;
    localparam logic [1:0] OP_RSV  = 2'd3;

    localparam logic [1:0] STS_OK   = 2'd0;
    localparam logic [1:0] STS_FAIL = 2'd2;

    // Reject out-of-range configurations at elaboration time.
    if (NO_MSTS < 1 || NO_MSTS > 8) begin : g_bad_no_msts
        $error("adam_dmi_arb: NO_MSTS must be in 1..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("adam_dmi_arb: TIMEOUT must be at least 1");
    end

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    grant_q, grant_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       op_q, op_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rsts_q, rsts_d;

`ifdef ADAM_DMI_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drain_q, drain_d;
    logic             timeout_hit;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [ABITS-1:0] sel_addr;
    logic [31:0]      sel_data;
    logic [1:0]       sel_op;
    logic             resp_ack;

    // Pointer to the master that gets first look after grant g, wrapping at NO_MSTS.
    function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] g);
        int n;
        n = int'(g) + 1;
        if (n >= NO_MSTS) begin
            n = 0;
        end
        return PW'(n);
    endfunction

    // Round-robin search: first valid master at or after the pointer, wrapping.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NO_MSTS; i++) begin
            idx = (int'(ptr_q) + i) % NO_MSTS;
            if (!win_found && mst_req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    // Route the winner's request fields, and the granted master's response ready.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_op   = OP_NOP;
        resp_ack = 1'b0;
        for (int i = 0; i < NO_MSTS; i++) begin
            if (int'(win_idx) == i) begin
                sel_addr = mst_req_addr[i*ABITS +: ABITS];
                sel_data = mst_req_data[i*32 +: 32];
                sel_op   = mst_req_op[i*2 +: 2];
            end
            if (int'(grant_q) == i) begin
                resp_ack = mst_resp_ready[i];
            end
        end
    end

    // Transaction FSM: accept, forward to the DM, await its reply, return it to the master.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rdata_d = rdata_q;
        rsts_d  = rsts_q;
`ifdef ADAM_DMI_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        drain_d = drain_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef ADAM_DMI_ARB_TIMEOUT_EN
                // The post-timeout drain window is exactly one IDLE cycle.
                drain_d = 1'b0;
`endif
                // A winner always sees ready, so a winner means a handshake.
                if (win_found) begin
                    grant_d = win_idx;
                    ptr_d   = ptr_after(win_idx);
                    addr_d  = sel_addr;
                    wdata_d = sel_data;
                    op_d    = sel_op;
                    if (sel_op == OP_RD || sel_op == OP_WR) begin
                        state_d = ST_FWD;
`ifdef ADAM_DMI_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // nop and reserved ops are answered locally.
                        state_d = ST_RESP;
                        rdata_d = '0;
                        rsts_d  = (sel_op == OP_RSV) ? STS_FAIL : STS_OK;
                    end
                end
            end
            ST_FWD: begin
                if (dm_req_ready) begin
                    state_d = ST_WAIT;
                end
`ifdef ADAM_DMI_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout_hit) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    rsts_d  = STS_FAIL;
                    drain_d = 1'b1;
                end
`endif
            end
            ST_WAIT: begin
                // A real response in the last counted cycle beats the timeout.
                if (dm_resp_valid) begin
                    state_d = ST_RESP;
                    rdata_d = dm_resp_data;
                    rsts_d  = dm_resp_op;
                end
`ifdef ADAM_DMI_ARB_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (timeout_hit) begin
                        state_d = ST_RESP;
                        rdata_d = '0;
                        rsts_d  = STS_FAIL;
                        drain_d = 1'b1;
                    end
                end
`endif
            end
            ST_RESP: begin
                if (resp_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; everything is zero outside the state that owns it.
    always_comb begin
        mst_req_ready  = '0;
        mst_resp_valid = '0;
        mst_resp_data  = '0;
        mst_resp_op    = '0;
        dm_req_valid   = 1'b0;
        dm_req_addr    = '0;
        dm_req_data    = '0;
        dm_req_op      = '0;
        dm_resp_ready  = (state_q == ST_WAIT);
`ifdef ADAM_DMI_ARB_TIMEOUT_EN
        dm_resp_ready  = dm_resp_ready | drain_q;
`endif
        for (int i = 0; i < NO_MSTS; i++) begin
            // Gate ready with rst_n so every output reads zero while reset is held.
            mst_req_ready[i]  = rst_n && (state_q == ST_IDLE) && win_found && (int'(win_idx) == i);
            mst_resp_valid[i] = (state_q == ST_RESP) && (int'(grant_q) == i);
        end
        if (state_q == ST_RESP) begin
            mst_resp_data = rdata_q;
            mst_resp_op   = rsts_q;
        end
        if (state_q == ST_FWD) begin
            dm_req_valid = 1'b1;
            dm_req_addr  = addr_q;
            dm_req_data  = wdata_q;
            dm_req_op    = op_q;
        end
    end

    // State and latched transaction registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            rdata_q <= '0;
            rsts_q  <= '0;
`ifdef ADAM_DMI_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            drain_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rdata_q <= rdata_d;
            rsts_q  <= rsts_d;
`ifdef ADAM_DMI_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
`endif
        end
    end

endmodule

// File: tb/tb_adam_dmi_arb.sv
// Directed testbench for adam_dmi_arb (NO_MSTS=2, ABITS=7, TIMEOUT=16).
// Inputs change just after the falling edge and outputs are sampled one
// step later, well away from the rising (active) edge.
module tb_adam_dmi_arb;

    localparam int NM = 2;
    localparam int AB = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM-1:0]     mst_req_valid = '0;
    logic [NM-1:0]     mst_req_ready;
    logic [NM*AB-1:0]  mst_req_addr = '0;
    logic [NM*32-1:0]  mst_req_data = '0;
    logic [NM*2-1:0]   mst_req_op = '0;
    logic [NM-1:0]     mst_resp_valid;
    logic [NM-1:0]     mst_resp_ready = '0;
    logic [31:0]       mst_resp_data;
    logic [1:0]        mst_resp_op;
    logic              dm_req_valid;
    logic              dm_req_ready = 1'b0;
    logic [AB-1:0]     dm_req_addr;
    logic [31:0]       dm_req_data;
    logic [1:0]        dm_req_op;
    logic              dm_resp_valid = 1'b0;
    logic              dm_resp_ready;
    logic [31:0]       dm_resp_data = '0;
    logic [1:0]        dm_resp_op = '0;

    int checks = 0;
    int errors = 0;

    adam_dmi_arb #(
        .NO_MSTS (NM),
        .ABITS   (AB),
        .TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mst_req_valid  (mst_req_valid),
        .mst_req_ready  (mst_req_ready),
        .mst_req_addr   (mst_req_addr),
        .mst_req_data   (mst_req_data),
        .mst_req_op     (mst_req_op),
        .mst_resp_valid (mst_resp_valid),
        .mst_resp_ready (mst_resp_ready),
        .mst_resp_data  (mst_resp_data),
        .mst_resp_op    (mst_resp_op),
        .dm_req_valid   (dm_req_valid),
        .dm_req_ready   (dm_req_ready),
        .dm_req_addr    (dm_req_addr),
        .dm_req_data    (dm_req_data),
        .dm_req_op      (dm_req_op),
        .dm_resp_valid  (dm_resp_valid),
        .dm_resp_ready  (dm_resp_ready),
        .dm_resp_data   (dm_resp_data),
        .dm_resp_op     (dm_resp_op)
    );

    always #5 clk = ~clk;

    // Advance to just after the next falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        mst_req_valid = 2'b11;
        mst_req_op    = {2'd1, 2'd1};
        cyc();
        cyc();
        checks++; if (mst_req_ready !== 2'b00) begin errors++; $display("FAIL rst_req_ready got %b exp 00", mst_req_ready); end
        checks++; if (mst_resp_valid !== 2'b00) begin errors++; $display("FAIL rst_resp_valid got %b exp 00", mst_resp_valid); end
        checks++; if ({mst_resp_data, mst_resp_op} !== 34'h0) begin errors++; $display("FAIL rst_resp_fields got %h/%h exp 0/0", mst_resp_data, mst_resp_op); end
        checks++; if ({dm_req_valid, dm_req_addr, dm_req_data, dm_req_op} !== 42'h0) begin errors++; $display("FAIL rst_dm_req got v%b a%h d%h o%h exp all 0", dm_req_valid, dm_req_addr, dm_req_data, dm_req_op); end
        checks++; if (dm_resp_ready !== 1'b0) begin errors++; $display("FAIL rst_dm_resp_ready got %b exp 0", dm_resp_ready); end
        mst_req_valid = 2'b00;
        mst_req_op    = '0;
        rst_n = 1'b1;
        cyc();
        checks++; if ({mst_req_ready, dm_req_valid, dm_resp_ready} !== 4'b0) begin errors++; $display("FAIL idle_after_rst got %b exp 0000", {mst_req_ready, dm_req_valid, dm_resp_ready}); end
    endtask

    task automatic test_single_read();
        mst_req_addr[6:0]  = 7'h11;
        mst_req_op[1:0]    = 2'd1;
        mst_req_data[31:0] = 32'h0;
        mst_req_valid      = 2'b01;
        #1;
        checks++; if (mst_req_ready !== 2'b01) begin errors++; $display("FAIL rd_accept got %b exp 01", mst_req_ready); end
        cyc();
        mst_req_valid = 2'b00;
        dm_req_ready  = 1'b1;
        #1;
        checks++; if ({dm_req_valid, dm_req_addr, dm_req_op} !== {1'b1, 7'h11, 2'd1}) begin errors++; $display("FAIL rd_fwd got v%b a%h o%h exp v1 a11 o1", dm_req_valid, dm_req_addr, dm_req_op); end
        checks++; if (dm_resp_ready !== 1'b0) begin errors++; $display("FAIL rd_fwd_resp_ready got %b exp 0", dm_resp_ready); end
        cyc();
        dm_req_ready  = 1'b0;
        dm_resp_valid = 1'b1;
        dm_resp_data  = 32'h0000_0382;
        dm_resp_op    = 2'd0;
        #1;
        checks++; if ({dm_req_valid, dm_resp_ready} !== 2'b01) begin errors++; $display("FAIL rd_wait got req_v%b resp_rdy%b exp 0 1", dm_req_valid, dm_resp_ready); end
        checks++; if (mst_resp_valid !== 2'b00) begin errors++; $display("FAIL rd_early_resp got %b exp 00", mst_resp_valid); end
        cyc();
        dm_resp_valid = 1'b0;
        #1;
        checks++; if (mst_resp_valid !== 2'b01) begin errors++; $display("FAIL rd_resp_valid got %b exp 01", mst_resp_valid); end
        checks++; if ({mst_resp_data, mst_resp_op} !== {32'h0000_0382, 2'd0}) begin errors++; $display("FAIL rd_resp_fields got %h/%h exp 00000382/0", mst_resp_data, mst_resp_op); end
        mst_resp_ready = 2'b01;
        cyc();
        mst_resp_ready = 2'b00;
        #1;
        checks++; if (mst_resp_valid !== 2'b00) begin errors++; $display("FAIL rd_resp_done got %b exp 00", mst_resp_valid); end
    endtask

    task automatic test_local_ops();
        mst_req_op[3:2] = 2'd0;
        mst_req_valid   = 2'b10;
        #1;
        checks++; if (mst_req_ready !== 2'b10) begin errors++; $display("FAIL nop_accept got %b exp 10", mst_req_ready); end
        cyc();
        mst_req_valid = 2'b00;
        #1;
        checks++; if (mst_resp_valid !== 2'b10) begin errors++; $display("FAIL nop_resp_valid got %b exp 10", mst_resp_valid); end
        checks++; if ({mst_resp_data, mst_resp_op} !== {32'h0, 2'd0}) begin errors++; $display("FAIL nop_resp_fields got %h/%h exp 00000000/0", mst_resp_data, mst_resp_op); end
        checks++; if (dm_req_valid !== 1'b0) begin errors++; $display("FAIL nop_dm_req got %b exp 0", dm_req_valid); end
        mst_resp_ready = 2'b10;
        cyc();
        mst_resp_ready  = 2'b00;
        mst_req_op[3:2] = 2'd3;
        mst_req_valid   = 2'b10;
        #1;
        checks++; if ({mst_resp_valid, mst_req_ready} !== 4'b0010) begin errors++; $display("FAIL rsv_accept got resp%b rdy%b exp 00 10", mst_resp_valid, mst_req_ready); end
        cyc();
        mst_req_valid = 2'b00;
        #1;
        checks++; if (mst_resp_valid !== 2'b10) begin errors++; $display("FAIL rsv_resp_valid got %b exp 10", mst_resp_valid); end
        checks++; if ({mst_resp_data, mst_resp_op} !== {32'h0, 2'd2}) begin errors++; $display("FAIL rsv_resp_fields got %h/%h exp 00000000/2", mst_resp_data, mst_resp_op); end
        checks++; if (dm_req_valid !== 1'b0) begin errors++; $display("FAIL rsv_dm_req got %b exp 0", dm_req_valid); end
        mst_resp_ready = 2'b10;
        cyc();
        mst_resp_ready = 2'b00;
        #1;
        checks++; if (mst_resp_valid !== 2'b00) begin errors++; $display("FAIL rsv_done got %b exp 00", mst_resp_valid); end
    endtask

    task automatic test_contention();
        mst_req_addr  = {7'h10, 7'h10};
        mst_req_data  = {32'h8000_0001, 32'h0000_0001};
        mst_req_op    = {2'd2, 2'd2};
        mst_req_valid = 2'b11;
        dm_req_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0]  oh;
            logic [31:0] wd;
            logic [31:0] rd;
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            wd = (k % 2 == 0) ? 32'h0000_0001 : 32'h8000_0001;
            rd = 32'h0000_00A0 + 32'(k);
            #1;
            checks++; if (mst_req_ready !== oh) begin errors++; $display("FAIL ctn_grant[%0d] got %b exp %b", k, mst_req_ready, oh); end
            cyc();
            #1;
            checks++; if ({dm_req_valid, dm_req_addr, dm_req_data, dm_req_op} !== {1'b1, 7'h10, wd, 2'd2}) begin errors++; $display("FAIL ctn_dm_req[%0d] got v%b a%h d%h o%h exp v1 a10 d%h o2", k, dm_req_valid, dm_req_addr, dm_req_data, dm_req_op, wd); end
            checks++; if (mst_req_ready !== 2'b00) begin errors++; $display("FAIL ctn_busy_ready[%0d] got %b exp 00", k, mst_req_ready); end
            cyc();
            dm_resp_valid = 1'b1;
            dm_resp_data  = rd;
            dm_resp_op    = 2'd0;
            cyc();
            dm_resp_valid = 1'b0;
            #1;
            checks++; if ({mst_resp_valid, mst_resp_data} !== {oh, rd}) begin errors++; $display("FAIL ctn_resp[%0d] got %b/%h exp %b/%h", k, mst_resp_valid, mst_resp_data, oh, rd); end
            mst_resp_ready = oh;
            cyc();
            mst_resp_ready = 2'b00;
        end
        mst_req_valid = 2'b00;
        dm_req_ready  = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure();
        mst_req_addr  = {7'h33, 7'h22};
        mst_req_op    = {2'd1, 2'd1};
        mst_req_valid = 2'b11;
        dm_req_ready  = 1'b0;
        #1;
        checks++; if (mst_req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept got %b exp 01", mst_req_ready); end
        cyc();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({dm_req_valid, dm_req_addr, dm_req_op, mst_req_ready} !== {1'b1, 7'h22, 2'd1, 2'b00}) begin errors++; $display("FAIL bp_req_hold[%0d] got v%b a%h o%h rdy%b exp v1 a22 o1 rdy00", i, dm_req_valid, dm_req_addr, dm_req_op, mst_req_ready); end
            cyc();
        end
        dm_req_ready = 1'b1;
        cyc();
        dm_req_ready  = 1'b0;
        dm_resp_valid = 1'b1;
        dm_resp_data  = 32'h1234_5678;
        dm_resp_op    = 2'd3;
        cyc();
        dm_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if ({mst_resp_valid, mst_resp_data, mst_resp_op, mst_req_ready} !== {2'b01, 32'h1234_5678, 2'd3, 2'b00}) begin errors++; $display("FAIL bp_resp_hold[%0d] got v%b d%h o%h rdy%b exp v01 d12345678 o3 rdy00", i, mst_resp_valid, mst_resp_data, mst_resp_op, mst_req_ready); end
            cyc();
        end
        mst_resp_ready = 2'b01;
        cyc();
        mst_resp_ready = 2'b00;
        #1;
        checks++; if ({mst_resp_valid, mst_req_ready} !== 4'b0010) begin errors++; $display("FAIL bp_next_grant got resp%b rdy%b exp 00 10", mst_resp_valid, mst_req_ready); end
        mst_req_valid = 2'b00;
        cyc();
    endtask

    task automatic test_reset_mid();
        mst_req_addr  = {7'h05, 7'h44};
        mst_req_op    = {2'd1, 2'd1};
        mst_req_valid = 2'b01;
        cyc();
        mst_req_valid = 2'b00;
        dm_req_ready  = 1'b1;
        cyc();
        dm_req_ready = 1'b0;
        #1;
        checks++; if (dm_resp_ready !== 1'b1) begin errors++; $display("FAIL rm_in_wait got %b exp 1", dm_resp_ready); end
        rst_n = 1'b0;
        #1;
        checks++; if ({dm_resp_ready, dm_req_valid, mst_resp_valid, mst_req_ready} !== 6'b0) begin errors++; $display("FAIL rm_async_ctrl got %b exp 000000", {dm_resp_ready, dm_req_valid, mst_resp_valid, mst_req_ready}); end
        checks++; if ({mst_resp_data, mst_resp_op, dm_req_addr, dm_req_data, dm_req_op} !== 75'h0) begin errors++; $display("FAIL rm_async_data got %h %h %h %h %h exp 0", mst_resp_data, mst_resp_op, dm_req_addr, dm_req_data, dm_req_op); end
        cyc();
        rst_n = 1'b1;
        mst_req_valid = 2'b11;
        #1;
        checks++; if (mst_req_ready !== 2'b01) begin errors++; $display("FAIL rm_ptr_zero got %b exp 01", mst_req_ready); end
        mst_req_valid = 2'b10;
        #1;
        checks++; if (mst_req_ready !== 2'b10) begin errors++; $display("FAIL rm_m1_accept got %b exp 10", mst_req_ready); end
        cyc();
        mst_req_valid = 2'b00;
        dm_req_ready  = 1'b1;
        #1;
        checks++; if ({dm_req_valid, dm_req_addr, dm_req_op} !== {1'b1, 7'h05, 2'd1}) begin errors++; $display("FAIL rm_fwd got v%b a%h o%h exp v1 a05 o1", dm_req_valid, dm_req_addr, dm_req_op); end
        cyc();
        dm_req_ready  = 1'b0;
        dm_resp_valid = 1'b1;
        dm_resp_data  = 32'hCAFE_F00D;
        dm_resp_op    = 2'd0;
        cyc();
        dm_resp_valid = 1'b0;
        #1;
        checks++; if ({mst_resp_valid, mst_resp_data, mst_resp_op} !== {2'b10, 32'hCAFE_F00D, 2'd0}) begin errors++; $display("FAIL rm_resp got v%b d%h o%h exp v10 dcafef00d o0", mst_resp_valid, mst_resp_data, mst_resp_op); end
        mst_resp_ready = 2'b10;
        cyc();
        mst_resp_ready = 2'b00;
        cyc();
    endtask

`ifdef ADAM_DMI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        mst_req_addr[6:0] = 7'h17;
        mst_req_op[1:0]   = 2'd1;
        mst_req_valid     = 2'b01;
        cyc();
        mst_req_valid = 2'b00;
        dm_req_ready  = 1'b1;
        #1;
        checks++; if (dm_req_valid !== 1'b1) begin errors++; $display("FAIL to_fwd got %b exp 1", dm_req_valid); end
        cyc();
        dm_req_ready = 1'b0;
        for (int n = 1; n < 16; n++) begin
            #1;
            checks++; if (mst_resp_valid !== 2'b00) begin errors++; $display("FAIL to_early[%0d] got %b exp 00", n, mst_resp_valid); end
            cyc();
        end
        dm_resp_valid = 1'b1;
        dm_resp_data  = 32'hDEAD_BEEF;
        dm_resp_op    = 2'd0;
        #1;
        checks++; if ({mst_resp_valid, mst_resp_data, mst_resp_op} !== {2'b01, 32'h0, 2'd2}) begin errors++; $display("FAIL to_resp got v%b d%h o%h exp v01 d00000000 o2", mst_resp_valid, mst_resp_data, mst_resp_op); end
        checks++; if (dm_resp_ready !== 1'b1) begin errors++; $display("FAIL to_drain_resp got %b exp 1", dm_resp_ready); end
        mst_resp_ready = 2'b01;
        cyc();
        dm_resp_valid  = 1'b0;
        mst_resp_ready = 2'b00;
        #1;
        checks++; if ({mst_resp_valid, mst_resp_data, dm_resp_ready} !== {2'b00, 32'h0, 1'b1}) begin errors++; $display("FAIL to_drain_idle got v%b d%h rdy%b exp v00 d0 rdy1", mst_resp_valid, mst_resp_data, dm_resp_ready); end
        cyc();
        checks++; if (dm_resp_ready !== 1'b0) begin errors++; $display("FAIL to_drain_end got %b exp 0", dm_resp_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_local_ops();
        test_contention();
        test_backpressure();
        test_reset_mid();
`ifdef ADAM_DMI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
